muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for RV32M multiply/divide. It runs iterative shift-add multiply and

---
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_seq.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake/bus bundle for the RV32M multiply/divide sequencer.
// The pipeline side uses the master modport, the sequencer uses slave.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] ReadData1;
   logic [XLEN-1:0] ReadData2;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, ReadData1, ReadData2, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, funct3, ReadData1, ReadData2, flush,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_FAST_EN to let div-by-0, signed overflow and multiply-by-0 skip the iterations.
module muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_seq_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_e;

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              neg_q, neg_d, rneg_q, rneg_d, spec_q, spec_d;
   logic              busy_q, busy_d, done_q, done_d;

   // Operand decode on the captured op
   logic            is_div, sgn_a, sgn_b, a_neg, b_neg, spec_now;
   logic [XLEN-1:0] a_abs, b_abs;

   assign is_div   = op_q[2];
   assign sgn_a    = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
   assign sgn_b    = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
   assign a_neg    = sgn_a & a_q[XLEN-1];
   assign b_neg    = sgn_b & b_q[XLEN-1];
   assign a_abs    = a_neg ? -a_q : a_q;
   assign b_abs    = b_neg ? -b_q : b_q;
`ifdef MULDIV_FAST_EN
   assign spec_now = (is_div & (b_q == '0))
                   | (is_div & ~op_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (&b_q))
                   | (~is_div & ((a_q == '0) | (b_q == '0)));
`else
   assign spec_now = (is_div & (b_q == '0))
                   | (is_div & ~op_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (&b_q));
`endif

   // One iteration of each algorithm; only the one matching the op is used
   logic [XLEN:0]   mul_sum, rem_sh, trial;
   logic [XLEN-1:0] hi_n, lo_n;

   always_comb begin
      mul_sum = {1'b0, hi_q} + {1'b0, a_q};
      rem_sh  = {hi_q, lo_q[XLEN-1]};
      trial   = rem_sh - {1'b0, b_q};
      if (is_div) begin
         // A clear top bit means the trial subtract did not borrow
         hi_n = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], ~trial[XLEN]};
      end else if (lo_q[0]) begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
      end else begin
         hi_n = {1'b0, hi_q[XLEN-1:1]};
         lo_n = {hi_q[0], lo_q[XLEN-1:1]};
      end
   end

   // Sign correction, result select and special-case substitution.
   // a/b are the raw operands whenever spec is set.
   function automatic logic [XLEN-1:0] final_result(
      input logic [2:0]      op,
      input logic [XLEN-1:0] hi, lo,
      input logic            neg, rneg, spec,
      input logic [XLEN-1:0] a, b
   );
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   quo, rem, res;
      prod = {hi, lo};
      if (neg) prod = -prod;
      quo = neg  ? -lo : lo;
      rem = rneg ? -hi : hi;
      if (spec) begin
         if (!op[2])         res = '0;
         else if (b == '0)   res = op[1] ? a : '1;
         else                res = op[1] ? '0 : a;
      end else if (op[2]) begin
         res = op[1] ? rem : quo;
      end else begin
         res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
      return res;
   endfunction

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      spec_d   = spec_q;
      result_d = result_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               state_d = PREP;
               op_d    = bus.funct3;
               a_d     = bus.ReadData1;
               b_d     = bus.ReadData2;
            end
         end
         PREP: begin
            // Special cases keep raw operands so DONE can return ReadData1 verbatim
            a_d     = spec_now ? a_q : a_abs;
            b_d     = spec_now ? b_q : b_abs;
            hi_d    = '0;
            lo_d    = is_div ? a_abs : b_abs;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            spec_d  = spec_now;
            cnt_d   = '0;
            state_d = CALC;
`ifdef MULDIV_FAST_EN
            if (spec_now) begin
               state_d  = DONE;
               result_d = final_result(op_q, '0, '0, 1'b0, 1'b0, 1'b1, a_q, b_q);
            end
`endif
         end
         CALC: begin
            hi_d = hi_n;
            lo_d = lo_n;
            if (cnt_q == CNT_W'(XLEN-1)) begin
               state_d  = DONE;
               result_d = final_result(op_q, hi_n, lo_n, neg_q, rneg_q, spec_q, a_q, b_q);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
      if (bus.flush) state_d = IDLE;
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // NOTE: sequential state uses only non-blocking assignments; blocking ones here would race with readers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         spec_q   <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         spec_q   <= spec_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; latency of special cases follows MULDIV_FAST_EN.
module tb_muldiv_seq;
   localparam int XLEN     = 32;
   localparam int FULL_LAT = XLEN + 1;   // edges from accept edge to the edge that raises done
`ifdef MULDIV_FAST_EN
   localparam int SPEC_LAT = 1;
`else
   localparam int SPEC_LAT = FULL_LAT;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   muldiv_seq_if #(.XLEN(XLEN)) bus ();
   muldiv_seq #(.XLEN(XLEN), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an op for one cycle, then scramble the inputs to prove they were captured.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start     = 1'b1;
      bus.funct3    = op;
      bus.ReadData1 = a;
      bus.ReadData2 = b;
      tick();
      bus.start     = 1'b0;
      bus.funct3    = ~op;
      bus.ReadData1 = 32'hDEAD_BEEF;
      bus.ReadData2 = 32'h0BAD_F00D;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (bus.done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic done_after);
      issue(op, a, b);
      wait_done(lat);
      res = bus.result;
      tick();
      done_after = bus.done;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
      bus.ReadData1 = '0; bus.ReadData2 = '0;
      #12;
      checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0)   begin errors++; $display("FAIL reset done: got %b want 0", bus.done); end
      checks++; if (bus.result !== '0)   begin errors++; $display("FAIL reset result: got %h want 0", bus.result); end
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic test_mul();
      logic [2:0]  op[5]   = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b011};
      logic [31:0] a[5]    = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
      logic [31:0] b[5]    = '{32'hFFFF_FFFA, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'h10};
      logic [31:0] want[5] = '{32'hFFFF_FFD6, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h1};
      logic [31:0] res; int lat; logic d_after;
      for (int i = 0; i < 5; i++) begin
         do_op(op[i], a[i], b[i], res, lat, d_after);
         checks++; if (res !== want[i]) begin errors++; $display("FAIL mul[%0d] result: got %h want %h", i, res, want[i]); end
         checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, FULL_LAT); end
         checks++; if (d_after !== 1'b0) begin errors++; $display("FAIL mul[%0d] done width: got %b want 0", i, d_after); end
      end
   endtask

   task automatic test_div();
      logic [2:0]  op[6]   = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
      logic [31:0] a[6]    = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
      logic [31:0] b[6]    = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      logic [31:0] want[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
      logic [31:0] res; int lat; logic d_after;
      for (int i = 0; i < 6; i++) begin
         do_op(op[i], a[i], b[i], res, lat, d_after);
         checks++; if (res !== want[i]) begin errors++; $display("FAIL div[%0d] result: got %h want %h", i, res, want[i]); end
         checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, FULL_LAT); end
         checks++; if (d_after !== 1'b0) begin errors++; $display("FAIL div[%0d] done width: got %b want 0", i, d_after); end
      end
   endtask

   task automatic test_special();
      logic [2:0]  op[8]   = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b110, 3'b100, 3'b110, 3'b000};
      logic [31:0] a[8]    = '{32'd5, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'hFFFF_FFF8,
                               32'h8000_0000, 32'h8000_0000, 32'd0};
      logic [31:0] b[8]    = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
      logic [31:0] want[8] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFF8,
                               32'h8000_0000, 32'd0, 32'd0};
      logic [31:0] res; int lat; logic d_after;
      for (int i = 0; i < 8; i++) begin
         do_op(op[i], a[i], b[i], res, lat, d_after);
         checks++; if (res !== want[i]) begin errors++; $display("FAIL special[%0d] result: got %h want %h", i, res, want[i]); end
         checks++; if (lat != SPEC_LAT) begin errors++; $display("FAIL special[%0d] latency: got %0d want %0d", i, lat, SPEC_LAT); end
         checks++; if (d_after !== 1'b0) begin errors++; $display("FAIL special[%0d] done width: got %b want 0", i, d_after); end
      end
   endtask

   task automatic test_flush();
      logic [31:0] res; int lat; logic d_after; int seen;
      do_op(3'b101, 32'd100, 32'd7, res, lat, d_after);
      checks++; if (res !== 32'd14) begin errors++; $display("FAIL flush setup result: got %h want 0000000e", res); end
      issue(3'b100, 32'hFFFF_FFF9, 32'd2);
      for (int i = 0; i < 8; i++) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL flush busy: got %b want 0", bus.busy); end
      checks++; if (bus.result !== 32'd14)   begin errors++; $display("FAIL flush result held: got %h want 0000000e", bus.result); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin tick(); if (bus.done) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL flush no done: got %0d pulses want 0", seen); end
      // flush and start together in IDLE: nothing is accepted
      bus.flush = 1'b1;
      issue(3'b000, 32'd3, 32'd4);
      bus.flush = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush+start busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_start_while_busy();
      int lat; int seen;
      issue(3'b101, 32'd100, 32'd7);
      for (int i = 0; i < 4; i++) tick();
      bus.start = 1'b1; bus.funct3 = 3'b000; bus.ReadData1 = 32'd3; bus.ReadData2 = 32'd4;
      tick();
      bus.start = 1'b0;
      wait_done(lat);
      checks++; if (lat + 5 != FULL_LAT) begin errors++; $display("FAIL ignore latency: got %0d want %0d", lat + 5, FULL_LAT); end
      checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL ignore result: got %h want 0000000e", bus.result); end
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore not queued busy: got %b want 0", bus.busy); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin tick(); if (bus.done) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL ignore not queued done: got %0d pulses want 0", seen); end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(3'b000, 32'd7, 32'hFFFF_FFFA);
      wait_done(lat);
      checks++; if (bus.result !== 32'hFFFF_FFD6) begin errors++; $display("FAIL b2b first result: got %h want ffffffd6", bus.result); end
      issue(3'b101, 32'd100, 32'd7);   // start raised during the done cycle
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b busy after accept: got %b want 1", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b done after accept: got %b want 0", bus.done); end
      wait_done(lat);
      checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL b2b latency: got %0d want %0d", lat, FULL_LAT); end
      checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL b2b second result: got %h want 0000000e", bus.result); end
      tick();
   endtask

   task automatic test_async_reset();
      logic [31:0] res; int lat; logic d_after;
      issue(3'b000, 32'h1234_5678, 32'd3);
      for (int i = 0; i < 10; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL areset busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0)  begin errors++; $display("FAIL areset done: got %b want 0", bus.done); end
      checks++; if (bus.result !== '0)  begin errors++; $display("FAIL areset result: got %h want 0", bus.result); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      do_op(3'b000, 32'd3, 32'd4, res, lat, d_after);
      checks++; if (res !== 32'd12)    begin errors++; $display("FAIL areset fresh mul: got %h want 0000000c", res); end
      checks++; if (lat != FULL_LAT)   begin errors++; $display("FAIL areset fresh latency: got %0d want %0d", lat, FULL_LAT); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_flush();
      test_start_while_busy();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
